// File: rtl/vga_timing_gen.sv
// VGA raster timing: free-running pixel/line counters with registered blank/sync/frame decodes.
// Optional macro VGA_TIMING_SYNC_DELAY_EN adds one register stage on blank/hsync/vsync.
module vga_timing_gen #(
    parameter int H_ACTIVE = 640,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FP     = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33
) (
    input  logic       vga_clk,
    input  logic       reset,
    output logic [9:0] DrawX,
    output logic [9:0] DrawY,
    output logic       blank,
    output logic       hsync,
    output logic       vsync,
    output logic       frame_tick,
    output logic [7:0] frame_count
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam logic [9:0] H_LAST   = 10'(H_TOTAL - 1);
    localparam logic [9:0] V_LAST   = 10'(V_TOTAL - 1);
    localparam logic [9:0] H_ACT    = 10'(H_ACTIVE);
    localparam logic [9:0] V_ACT    = 10'(V_ACTIVE);
    localparam logic [9:0] HS_START = 10'(H_ACTIVE + H_FP);
    localparam logic [9:0] HS_END   = 10'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [9:0] VS_START = 10'(V_ACTIVE + V_FP);
    localparam logic [9:0] VS_END   = 10'(V_ACTIVE + V_FP + V_SYNC);

    logic [9:0] hc, vc;
    logic [9:0] hc_next, vc_next;
    logic       blank_next, hsync_next, vsync_next, tick_next;
    logic       blank_p0, hsync_p0, vsync_p0;

    always_comb begin
        hc_next = hc + 10'd1;
        vc_next = vc;
        if (hc == H_LAST) begin
            hc_next = '0;
            vc_next = (vc == V_LAST) ? '0 : vc + 10'd1;
        end
    end

    // Decode the upcoming position so each flag lands together with the count it describes.
    always_comb begin
        blank_next = (hc_next < H_ACT) && (vc_next < V_ACT);
        hsync_next = !((hc_next >= HS_START) && (hc_next < HS_END));
        vsync_next = !((vc_next >= VS_START) && (vc_next < VS_END));
        tick_next  = (hc_next == 10'd0) && (vc_next == V_ACT);
    end

    // Stage p0: counters and registered decodes
    always_ff @(posedge vga_clk or posedge reset) begin
        if (reset) begin
            hc          <= '0;
            vc          <= '0;
            blank_p0    <= 1'b1;
            hsync_p0    <= 1'b1;
            vsync_p0    <= 1'b1;
            frame_tick  <= 1'b0;
            frame_count <= '0;
        end else begin
            hc          <= hc_next;
            vc          <= vc_next;
            blank_p0    <= blank_next;
            hsync_p0    <= hsync_next;
            vsync_p0    <= vsync_next;
            frame_tick  <= tick_next;
            if (tick_next)
                frame_count <= frame_count + 8'd1;
        end
    end

    assign DrawX = hc;
    assign DrawY = vc;

`ifdef VGA_TIMING_SYNC_DELAY_EN
    logic blank_p1, hsync_p1, vsync_p1;

    // Stage p1: lag blank/sync by one cycle to match the renderers' registered color
    always_ff @(posedge vga_clk or posedge reset) begin
        if (reset) begin
            blank_p1 <= 1'b1;
            hsync_p1 <= 1'b1;
            vsync_p1 <= 1'b1;
        end else begin
            blank_p1 <= blank_p0;
            hsync_p1 <= hsync_p0;
            vsync_p1 <= vsync_p0;
        end
    end

    assign blank = blank_p1;
    assign hsync = hsync_p1;
    assign vsync = vsync_p1;
`else
    assign blank = blank_p0;
    assign hsync = hsync_p0;
    assign vsync = vsync_p0;
`endif

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: a default-size instance for line timing and a small-raster instance for frame behaviour.
module tb_vga_timing_gen;

`ifdef VGA_TIMING_SYNC_DELAY_EN
    localparam int LAG = 1;
`else
    localparam int LAG = 0;
`endif

    // Small raster: 25 x 17 = 425 cycles per frame
    localparam int S_HA = 16, S_HFP = 2, S_HS = 3, S_HBP = 4;
    localparam int S_VA = 10, S_VFP = 2, S_VS = 2, S_VBP = 3;
    localparam int S_HT = S_HA + S_HFP + S_HS + S_HBP;
    localparam int S_VT = S_VA + S_VFP + S_VS + S_VBP;
    localparam int S_FR = S_HT * S_VT;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [9:0] dx_d, dy_d, dx_s, dy_s;
    logic       bl_d, hs_d, vs_d, tk_d, bl_s, hs_s, vs_s, tk_s;
    logic [7:0] fc_d, fc_s;
    int         errors = 0;
    int         checks = 0;

    always #5 clk = ~clk;

    vga_timing_gen dut_d (
        .vga_clk(clk), .reset(reset), .DrawX(dx_d), .DrawY(dy_d), .blank(bl_d),
        .hsync(hs_d), .vsync(vs_d), .frame_tick(tk_d), .frame_count(fc_d)
    );

    vga_timing_gen #(
        .H_ACTIVE(S_HA), .H_FP(S_HFP), .H_SYNC(S_HS), .H_BP(S_HBP),
        .V_ACTIVE(S_VA), .V_FP(S_VFP), .V_SYNC(S_VS), .V_BP(S_VBP)
    ) dut_s (
        .vga_clk(clk), .reset(reset), .DrawX(dx_s), .DrawY(dy_s), .blank(bl_s),
        .hsync(hs_s), .vsync(vs_s), .frame_tick(tk_s), .frame_count(fc_s)
    );

    // Expected {blank, hsync, vsync} for a raster position
    function automatic logic [2:0] dec(input int x, input int y, input int ha, input int hfp,
                                       input int hs, input int va, input int vfp, input int vs);
        logic b, h, v;
        b = (x < ha) && (y < va);
        h = !((x >= ha + hfp) && (x < ha + hfp + hs));
        v = !((y >= va + vfp) && (y < va + vfp + vs));
        return {b, h, v};
    endfunction

    // Expected frame_count k cycles after reset release
    function automatic int fcnt(input int k, input int ht, input int vt, input int va);
        if (k < va * ht) return 0;
        return ((k - va * ht) / (ht * vt) + 1) % 256;
    endfunction

    task automatic apply_reset();
        reset = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        @(negedge clk);
        checks += 14;
        if (dx_d !== 10'd0) begin errors++; $display("FAIL reset_dx_d got=%0d exp=0", dx_d); end
        if (dy_d !== 10'd0) begin errors++; $display("FAIL reset_dy_d got=%0d exp=0", dy_d); end
        if (bl_d !== 1'b1)  begin errors++; $display("FAIL reset_blank_d got=%b exp=1", bl_d); end
        if (hs_d !== 1'b1)  begin errors++; $display("FAIL reset_hsync_d got=%b exp=1", hs_d); end
        if (vs_d !== 1'b1)  begin errors++; $display("FAIL reset_vsync_d got=%b exp=1", vs_d); end
        if (tk_d !== 1'b0)  begin errors++; $display("FAIL reset_tick_d got=%b exp=0", tk_d); end
        if (fc_d !== 8'd0)  begin errors++; $display("FAIL reset_fc_d got=%0d exp=0", fc_d); end
        if (dx_s !== 10'd0) begin errors++; $display("FAIL reset_dx_s got=%0d exp=0", dx_s); end
        if (dy_s !== 10'd0) begin errors++; $display("FAIL reset_dy_s got=%0d exp=0", dy_s); end
        if (bl_s !== 1'b1)  begin errors++; $display("FAIL reset_blank_s got=%b exp=1", bl_s); end
        if (hs_s !== 1'b1)  begin errors++; $display("FAIL reset_hsync_s got=%b exp=1", hs_s); end
        if (vs_s !== 1'b1)  begin errors++; $display("FAIL reset_vsync_s got=%b exp=1", vs_s); end
        if (tk_s !== 1'b0)  begin errors++; $display("FAIL reset_tick_s got=%b exp=0", tk_s); end
        if (fc_s !== 8'd0)  begin errors++; $display("FAIL reset_fc_s got=%0d exp=0", fc_s); end
    endtask

    // Default 640x480 timing over two lines, plus hsync/blank edge positions in line 0
    task automatic test_line();
        int ex, ey, ks;
        logic [2:0] e;
        int low_cnt = 0, first_low = -1, first_high = -1, blank_fall = -1;
        apply_reset();
        for (int k = 1; k <= 1700; k++) begin
            @(negedge clk);
            ex = k % 800;
            ey = (k / 800) % 525;
            ks = (k >= LAG) ? k - LAG : 0;
            e  = dec(ks % 800, (ks / 800) % 525, 640, 16, 96, 480, 10, 2);
            checks += 6;
            if (dx_d !== 10'(ex)) begin errors++; $display("FAIL line_dx k=%0d got=%0d exp=%0d", k, dx_d, ex); end
            if (dy_d !== 10'(ey)) begin errors++; $display("FAIL line_dy k=%0d got=%0d exp=%0d", k, dy_d, ey); end
            if (bl_d !== e[2]) begin errors++; $display("FAIL line_blank k=%0d got=%b exp=%b", k, bl_d, e[2]); end
            if (hs_d !== e[1]) begin errors++; $display("FAIL line_hsync k=%0d got=%b exp=%b", k, hs_d, e[1]); end
            if (vs_d !== e[0]) begin errors++; $display("FAIL line_vsync k=%0d got=%b exp=%b", k, vs_d, e[0]); end
            if (tk_d !== 1'b0 || fc_d !== 8'd0) begin
                errors++; $display("FAIL line_tick k=%0d got=%b/%0d exp=0/0", k, tk_d, fc_d);
            end
            if (k < 800) begin
                if (!hs_d) low_cnt++;
                if (!hs_d && first_low < 0) first_low = int'(dx_d);
                if (hs_d && first_low >= 0 && first_high < 0) first_high = int'(dx_d);
                if (!bl_d && blank_fall < 0) blank_fall = int'(dx_d);
            end
        end
        checks += 4;
        if (low_cnt != 96) begin errors++; $display("FAIL hsync_width got=%0d exp=96", low_cnt); end
        if (first_low != 656 + LAG) begin errors++; $display("FAIL hsync_fall_x got=%0d exp=%0d", first_low, 656 + LAG); end
        if (first_high != 752 + LAG) begin errors++; $display("FAIL hsync_rise_x got=%0d exp=%0d", first_high, 752 + LAG); end
        if (blank_fall != 640 + LAG) begin errors++; $display("FAIL blank_fall_x got=%0d exp=%0d", blank_fall, 640 + LAG); end
    endtask

    // Small raster over three frames: wrap, vsync width, frame_tick and frame_count
    task automatic test_frame();
        int ex, ey, ks;
        logic [2:0] e;
        int ticks = 0, vs_low = 0;
        apply_reset();
        for (int k = 1; k <= 3 * S_FR + 30; k++) begin
            @(negedge clk);
            ex = k % S_HT;
            ey = (k / S_HT) % S_VT;
            ks = (k >= LAG) ? k - LAG : 0;
            e  = dec(ks % S_HT, (ks / S_HT) % S_VT, S_HA, S_HFP, S_HS, S_VA, S_VFP, S_VS);
            checks += 7;
            if (dx_s !== 10'(ex)) begin errors++; $display("FAIL frame_dx k=%0d got=%0d exp=%0d", k, dx_s, ex); end
            if (dy_s !== 10'(ey)) begin errors++; $display("FAIL frame_dy k=%0d got=%0d exp=%0d", k, dy_s, ey); end
            if (bl_s !== e[2]) begin errors++; $display("FAIL frame_blank k=%0d got=%b exp=%b", k, bl_s, e[2]); end
            if (hs_s !== e[1]) begin errors++; $display("FAIL frame_hsync k=%0d got=%b exp=%b", k, hs_s, e[1]); end
            if (vs_s !== e[0]) begin errors++; $display("FAIL frame_vsync k=%0d got=%b exp=%b", k, vs_s, e[0]); end
            if (tk_s !== ((ex == 0) && (ey == S_VA))) begin
                errors++; $display("FAIL frame_tick k=%0d got=%b x=%0d y=%0d", k, tk_s, ex, ey);
            end
            if (fc_s !== 8'(fcnt(k, S_HT, S_VT, S_VA))) begin
                errors++; $display("FAIL frame_count k=%0d got=%0d exp=%0d", k, fc_s, fcnt(k, S_HT, S_VT, S_VA));
            end
            if (tk_s) ticks++;
            if (k <= S_FR && !vs_s) vs_low++;
        end
        checks += 3;
        if (ticks != 3) begin errors++; $display("FAIL tick_total got=%0d exp=3", ticks); end
        if (fc_s !== 8'd3) begin errors++; $display("FAIL fc_after_3 got=%0d exp=3", fc_s); end
        if (vs_low != S_VS * S_HT) begin errors++; $display("FAIL vsync_width got=%0d exp=%0d", vs_low, S_VS * S_HT); end
    endtask

    // Asynchronous reset in the middle of the third frame, then a clean restart
    task automatic test_mid_reset();
        int ex, ey, ks;
        logic [2:0] e;
        apply_reset();
        repeat (2 * S_FR + 5 * S_HT + 7) @(negedge clk);
        checks += 3;
        if (fc_s !== 8'd2) begin errors++; $display("FAIL pre_reset_fc got=%0d exp=2", fc_s); end
        if (dx_s !== 10'd7) begin errors++; $display("FAIL pre_reset_dx got=%0d exp=7", dx_s); end
        if (dy_s !== 10'd5) begin errors++; $display("FAIL pre_reset_dy got=%0d exp=5", dy_s); end
        #2 reset = 1'b1;
        #1;
        checks += 6;
        if (dx_s !== 10'd0) begin errors++; $display("FAIL async_dx got=%0d exp=0", dx_s); end
        if (dy_s !== 10'd0) begin errors++; $display("FAIL async_dy got=%0d exp=0", dy_s); end
        if (fc_s !== 8'd0)  begin errors++; $display("FAIL async_fc got=%0d exp=0", fc_s); end
        if ({bl_s, hs_s, vs_s, tk_s} !== 4'b1110) begin
            errors++; $display("FAIL async_flags got=%b exp=1110", {bl_s, hs_s, vs_s, tk_s});
        end
        if (dx_d !== 10'd0) begin errors++; $display("FAIL async_dx_d got=%0d exp=0", dx_d); end
        if ({bl_d, hs_d, vs_d, tk_d} !== 4'b1110) begin
            errors++; $display("FAIL async_flags_d got=%b exp=1110", {bl_d, hs_d, vs_d, tk_d});
        end
        repeat (2) @(posedge clk);
        @(negedge clk);
        checks += 2;
        if (dx_s !== 10'd0) begin errors++; $display("FAIL held_dx got=%0d exp=0", dx_s); end
        if (fc_s !== 8'd0)  begin errors++; $display("FAIL held_fc got=%0d exp=0", fc_s); end
        reset = 1'b0;
        for (int k = 1; k <= S_FR + 75; k++) begin
            @(negedge clk);
            ex = k % S_HT;
            ey = (k / S_HT) % S_VT;
            ks = (k >= LAG) ? k - LAG : 0;
            e  = dec(ks % S_HT, (ks / S_HT) % S_VT, S_HA, S_HFP, S_HS, S_VA, S_VFP, S_VS);
            checks += 4;
            if (dx_s !== 10'(ex) || dy_s !== 10'(ey)) begin
                errors++; $display("FAIL restart_pos k=%0d got=%0d,%0d exp=%0d,%0d", k, dx_s, dy_s, ex, ey);
            end
            if ({bl_s, hs_s, vs_s} !== e) begin
                errors++; $display("FAIL restart_flags k=%0d got=%b exp=%b", k, {bl_s, hs_s, vs_s}, e);
            end
            if (tk_s !== ((ex == 0) && (ey == S_VA))) begin
                errors++; $display("FAIL restart_tick k=%0d got=%b", k, tk_s);
            end
            if (fc_s !== 8'(fcnt(k, S_HT, S_VT, S_VA))) begin
                errors++; $display("FAIL restart_fc k=%0d got=%0d exp=%0d", k, fc_s, fcnt(k, S_HT, S_VT, S_VA));
            end
        end
    endtask

    initial begin
        test_reset();
        test_line();
        test_frame();
        test_mid_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
